// File: rtl/reflet_prefetch_addr_if.sv
// Memory-side bus of the Reflet prefetching address unit.
// One request at a time; the master holds addr/data_out/read_en/write_en
// until the slave answers with mem_ready for one cycle.
//   addr      master -> slave  byte address of the request
//   data_out  master -> slave  write data
//   read_en   master -> slave  read request
//   write_en  master -> slave  write request
//   data_in   slave -> master  read data, valid while mem_ready is high
//   mem_ready slave -> master  completes the current request this cycle
interface reflet_prefetch_addr_if #(
    parameter int wordsize = 16
);
    logic [wordsize-1:0] addr;
    logic [wordsize-1:0] data_out;
    logic [wordsize-1:0] data_in;
    logic                read_en;
    logic                write_en;
    logic                mem_ready;

    modport master (
        output addr, data_out, read_en, write_en,
        input  data_in, mem_ready
    );

    modport slave (
        input  addr, data_out, read_en, write_en,
        output data_in, mem_ready
    );
endinterface

// File: rtl/reflet_prefetch_addr.sv
// Reflet CPU-to-RAM address unit with an instruction prefetch FIFO.
// Owns the single memory port. CPU data accesses take priority over
// instruction prefetch; prefetched words are kept as {word, aligned address}
// and the byte at pc is served from the FIFO head.
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   enable                low freezes every register and blocks new requests
//   pc                    byte address of the wanted instruction
//   instruction           byte at pc (0 when inst_ready is low)
//   inst_ready            instruction valid for pc
//   inst_take             CPU consumes the instruction this cycle
//   data_req/we/addr/wdata  data access request, held until data_done
//   data_rdata            registered read data, holds until the next read
//   data_done             one-cycle completion pulse
//   mem                   memory bus (master side)
module reflet_prefetch_addr #(
    parameter int wordsize    = 16,
    parameter int fetch_depth = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic [wordsize-1:0] pc,
    output logic [7:0]          instruction,
    output logic                inst_ready,
    input  logic                inst_take,
    input  logic                data_req,
    input  logic                data_we,
    input  logic [wordsize-1:0] data_addr,
    input  logic [wordsize-1:0] data_wdata,
    output logic [wordsize-1:0] data_rdata,
    output logic                data_done,
    reflet_prefetch_addr_if.master mem
);
    localparam int B  = wordsize / 8;
    localparam int PW = $clog2(fetch_depth);
    localparam int CW = PW + 1;
    localparam logic [wordsize-1:0] LOW_MASK = wordsize'(B - 1);

    typedef enum logic [1:0] {IDLE, FETCH, DATA_RD, DATA_WR} state_t;

    state_t              state;
    logic [wordsize-1:0] fetch_addr;
    logic                epoch;
    logic                fetch_epoch;
    logic [PW-1:0]       rd_ptr;
    logic [PW-1:0]       wr_ptr;
    logic [CW-1:0]       count;

    logic [wordsize-1:0] fifo_word [fetch_depth];
    logic [wordsize-1:0] fifo_addr [fetch_depth];
    logic [fetch_depth-1:0] entry_valid;

    logic [wordsize-1:0] aligned_pc, byte_idx, shifted, write_line, fetch_base;
    logic empty, head_match, flush_branch, wr_hit, wr_flush, flush;
    logic done, push, pop, in_flight, start_data, start_fetch;

    assign aligned_pc = pc & ~LOW_MASK;
    assign byte_idx   = pc & LOW_MASK;
    assign empty      = (count == '0);
    assign head_match = (fifo_addr[rd_ptr] == aligned_pc);
    assign in_flight  = (state == FETCH);

    // An entry is live when its distance from the read pointer is below count.
    for (genvar g = 0; g < fetch_depth; g++) begin : g_valid
        logic [PW-1:0] off;
        assign off            = PW'(g) - rd_ptr;
        assign entry_valid[g] = ({1'b0, off} < count);
    end

    assign write_line = mem.addr & ~LOW_MASK;

    always_comb begin
        wr_hit = 1'b0;
        for (int i = 0; i < fetch_depth; i++) begin
            if (entry_valid[i] && fifo_addr[i] == write_line) wr_hit = 1'b1;
        end
    end

    assign done         = enable && mem.mem_ready && (state != IDLE);
    assign wr_flush     = done && (state == DATA_WR) && wr_hit;
    assign flush_branch = !empty && !head_match;
    assign flush        = flush_branch || wr_flush;

    assign inst_ready  = !empty && head_match && !wr_flush;
    assign shifted     = fifo_word[rd_ptr] >> (byte_idx << 3);
    assign instruction = inst_ready ? shifted[7:0] : 8'h00;

    // A word is released only once its last byte has been consumed.
    assign pop  = enable && inst_ready && inst_take && (byte_idx == LOW_MASK);
    // Fetches issued before the last flush carry a stale epoch and are dropped.
    assign push = done && in_flight && (fetch_epoch == epoch) && !flush;

    // With nothing buffered or pending, prefetch follows pc directly.
    assign fetch_base  = (empty && !in_flight) ? aligned_pc : fetch_addr;
    assign start_data  = (state == IDLE) && data_req && !data_done;
    assign start_fetch = (state == IDLE) && !start_data && !flush &&
                         (count < CW'(fetch_depth));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            mem.addr     <= '0;
            mem.data_out <= '0;
            mem.read_en  <= 1'b0;
            mem.write_en <= 1'b0;
            data_rdata   <= '0;
            data_done    <= 1'b0;
            fetch_addr   <= '0;
            epoch        <= 1'b0;
            fetch_epoch  <= 1'b0;
            rd_ptr       <= '0;
            wr_ptr       <= '0;
            count        <= '0;
        end else if (enable) begin
            data_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_data) begin
                        state        <= data_we ? DATA_WR : DATA_RD;
                        mem.addr     <= data_addr;
                        mem.data_out <= data_wdata;
                        mem.write_en <= data_we;
                        mem.read_en  <= !data_we;
                    end else if (start_fetch) begin
                        state       <= FETCH;
                        mem.addr    <= fetch_base;
                        mem.read_en <= 1'b1;
                        fetch_epoch <= epoch;
                    end
                end
                default: begin
                    if (mem.mem_ready) begin
                        state        <= IDLE;
                        mem.read_en  <= 1'b0;
                        mem.write_en <= 1'b0;
                        if (state != FETCH) data_done <= 1'b1;
                        if (state == DATA_RD) data_rdata <= mem.data_in;
                    end
                end
            endcase

            if (flush) begin
                rd_ptr     <= '0;
                wr_ptr     <= '0;
                count      <= '0;
                epoch      <= ~epoch;
                fetch_addr <= aligned_pc;
            end else begin
                if (push) wr_ptr <= wr_ptr + PW'(1);
                if (pop)  rd_ptr <= rd_ptr + PW'(1);
                case ({push, pop})
                    2'b10:   count <= count + CW'(1);
                    2'b01:   count <= count - CW'(1);
                    default: count <= count;
                endcase
                if (start_fetch) begin
                    fetch_addr <= fetch_base + wordsize'(B);
                end else if (empty && !in_flight) begin
                    fetch_addr <= aligned_pc;
                end
            end
        end
    end

    // FIFO payload carries no reset; occupancy alone decides validity.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_word[wr_ptr] <= mem.data_in;
            fifo_addr[wr_ptr] <= mem.addr & ~LOW_MASK;
        end
    end
endmodule

// File: tb/tb_reflet_prefetch_addr.sv
// Self-checking bench for reflet_prefetch_addr (wordsize 16, depth 4).
// A behavioural RAM with programmable wait states answers the memory bus;
// scoreboard queues hold expected memory requests, instruction bytes and
// data read results.
module tb_reflet_prefetch_addr;
    localparam int W = 16;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         enable = 1'b1;
    logic [W-1:0] pc = '0;
    logic [7:0]   instruction;
    logic         inst_ready;
    logic         inst_take = 1'b0;
    logic         data_req = 1'b0;
    logic         data_we = 1'b0;
    logic [W-1:0] data_addr = '0;
    logic [W-1:0] data_wdata = '0;
    logic [W-1:0] data_rdata;
    logic         data_done;

    reflet_prefetch_addr_if #(.wordsize(W)) mem_bus ();

    reflet_prefetch_addr #(.wordsize(W), .fetch_depth(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .pc          (pc),
        .instruction (instruction),
        .inst_ready  (inst_ready),
        .inst_take   (inst_take),
        .data_req    (data_req),
        .data_we     (data_we),
        .data_addr   (data_addr),
        .data_wdata  (data_wdata),
        .data_rdata  (data_rdata),
        .data_done   (data_done),
        .mem         (mem_bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Behavioural RAM
    logic [15:0] ram [32768];
    int  mem_wait = 0;
    int  wcnt = 0;
    wire req = mem_bus.read_en | mem_bus.write_en;
    assign mem_bus.mem_ready = req && (wcnt >= mem_wait);
    assign mem_bus.data_in   = ram[mem_bus.addr[15:1]];

    always @(posedge clk) begin
        if (req && !mem_bus.mem_ready) wcnt <= wcnt + 1;
        else wcnt <= 0;
        if (mem_bus.write_en && mem_bus.mem_ready) ram[mem_bus.addr[15:1]] <= mem_bus.data_out;
    end

    // Memory request scoreboard
    typedef struct packed { logic we; logic [15:0] a; } req_t;
    req_t exp_req[$];
    int   extra_req = 0;
    bit   strict = 1'b0;

    task automatic exp_push(input logic we, input logic [15:0] a);
        exp_req.push_back('{we: we, a: a});
    endtask

    always @(negedge clk) begin
        if (!reset && req) chk_val("rw_exclusive", mem_bus.read_en & mem_bus.write_en, 0);
        if (!reset && req && mem_bus.mem_ready) begin
            if (exp_req.size() > 0) begin
                chk_val("req_addr", mem_bus.addr, exp_req[0].a);
                chk_val("req_we", mem_bus.write_en, exp_req[0].we);
                void'(exp_req.pop_front());
            end else if (strict) begin
                extra_req <= extra_req + 1;
            end
        end
    end

    // Data completion scoreboard
    logic [15:0] exp_rd[$];
    int done_pulses = 0;
    always @(negedge clk) begin
        if (!reset && data_done) begin
            done_pulses <= done_pulses + 1;
            if (exp_rd.size() > 0) begin
                chk_val("data_rdata", data_rdata, exp_rd[0]);
                void'(exp_rd.pop_front());
            end else begin
                chk_val("data_done_unexpected", 1, 0);
            end
        end
    end

    int max_cnt = 0;
    always @(negedge clk) begin
        if (!reset && int'(dut.count) > max_cnt) max_cnt <= int'(dut.count);
    end

    // Instruction scoreboard
    logic [7:0] exp_ins[$];

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic fetch_byte(input logic [15:0] a, input logic [7:0] e, output int waited);
        int n;
        n = 0;
        pc = a;
        inst_take = 1'b1;
        exp_ins.push_back(e);
        @(negedge clk);
        while (!inst_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        waited = n;
        if (!inst_ready) begin
            chk_val("inst_timeout", 0, 1);
            void'(exp_ins.pop_front());
        end else begin
            chk_val("instruction", instruction, exp_ins[0]);
            void'(exp_ins.pop_front());
        end
        @(posedge clk);
        #1 inst_take = 1'b0;
    endtask

    task automatic data_access(input logic we, input logic [15:0] a, input logic [15:0] wd,
                               input logic [15:0] exp_rdata);
        int n;
        n = 0;
        exp_rd.push_back(exp_rdata);
        data_we = we;
        data_addr = a;
        data_wdata = wd;
        data_req = 1'b1;
        do begin
            @(negedge clk);
            n++;
        end while (!data_done && n < 50);
        if (!data_done) chk_val("data_timeout", 0, 1);
        @(posedge clk);
        #1 data_req = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        int wsum;
        int n;
        int d0;
        logic [7:0] store_bytes [6];

        for (int i = 0; i < 32768; i++) ram[i] = {8'(17 * (2 * i + 2)), 8'(17 * (2 * i + 1))};
        ram[16'h0080] = 16'hC3D4;
        ram[16'h7FFF] = 16'hA55A;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_val("rst_addr", mem_bus.addr, 0);
        chk_val("rst_data_out", mem_bus.data_out, 0);
        chk_val("rst_read_en", mem_bus.read_en, 0);
        chk_val("rst_write_en", mem_bus.write_en, 0);
        chk_val("rst_data_rdata", data_rdata, 0);
        chk_val("rst_data_done", data_done, 0);
        chk_val("rst_instruction", instruction, 0);
        chk_val("rst_inst_ready", inst_ready, 0);

        // Sequential execution from 0 with a zero-wait memory
        @(posedge clk);
        #1 reset = 1'b0;
        wsum = 0;
        for (int a = 0; a < 16; a++) begin
            fetch_byte(16'(a), 8'(17 * (a + 1)), w);
            if (a >= 2) wsum += w;
        end
        chk_val("steady_ready_stalls", wsum, 0);

        // FIFO fill with pc held at 0
        exp_push(0, 16'h0000);
        exp_push(0, 16'h0002);
        exp_push(0, 16'h0004);
        exp_push(0, 16'h0006);
        strict = 1'b1;
        pc = 16'h0000;
        inst_take = 1'b0;
        do_reset();
        repeat (30) @(negedge clk);
        chk_val("fill_reqs_left", exp_req.size(), 0);
        chk_val("fill_extra_reqs", extra_req, 0);
        chk_val("fill_read_idle", mem_bus.read_en, 0);
        chk_val("fill_inst_ready", inst_ready, 1);
        chk_val("fill_instruction", instruction, 8'h11);
        strict = 1'b0;

        // Branch from 2 to 0x40 while the fetch of 8 is waiting on memory
        @(posedge clk);
        #1 mem_wait = 3;
        exp_push(0, 16'h0008);
        exp_push(0, 16'h0040);
        pc = 16'h0001;
        inst_take = 1'b1;
        @(posedge clk);
        #1 pc = 16'h0002;
        inst_take = 1'b0;
        n = 0;
        @(negedge clk);
        while (!mem_bus.read_en && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk_val("branch_fetch_started", mem_bus.read_en, 1);
        chk_val("branch_fetch_addr", mem_bus.addr, 16'h0008);
        @(posedge clk);
        #1 pc = 16'h0040;
        mem_wait = 0;
        n = 0;
        @(negedge clk);
        while (!inst_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk_val("branch_latency", n, 3);
        chk_val("branch_instruction", instruction, 8'h51);
        chk_val("branch_reqs_left", exp_req.size(), 0);

        // Data read at 0x100 competing with the first prefetch
        exp_req.delete();
        exp_push(0, 16'h0100);
        exp_push(0, 16'h0000);
        pc = 16'h0000;
        inst_take = 1'b0;
        d0 = done_pulses;
        do_reset();
        data_access(0, 16'h0100, 16'h0000, 16'hC3D4);
        repeat (5) @(negedge clk);
        chk_val("read_done_pulses", done_pulses - d0, 1);
        chk_val("read_rdata_hold", data_rdata, 16'hC3D4);
        chk_val("read_reqs_left", exp_req.size(), 0);

        // Store into a buffered word; FIFO must refetch and show the new data
        repeat (20) @(negedge clk);
        exp_push(1, 16'h0004);
        exp_push(0, 16'h0000);
        exp_push(0, 16'h0002);
        exp_push(0, 16'h0004);
        exp_push(0, 16'h0006);
        @(posedge clk);
        #1 data_access(1, 16'h0004, 16'hBEEF, 16'hC3D4);
        repeat (20) @(negedge clk);
        chk_val("store_reqs_left", exp_req.size(), 0);
        @(posedge clk);
        #1;
        store_bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'hEF, 8'hBE};
        for (int a = 0; a < 6; a++) fetch_byte(16'(a), store_bytes[a], w);

        // Reset during a pending fetch, then address wrap at the top of memory
        mem_wait = 3;
        pc = 16'h0020;
        exp_req.delete();
        do_reset();
        n = 0;
        @(negedge clk);
        while (!mem_bus.read_en && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk_val("midrst_fetch_started", mem_bus.read_en, 1);
        #1 reset = 1'b1;
        #1;
        chk_val("midrst_read_en", mem_bus.read_en, 0);
        chk_val("midrst_write_en", mem_bus.write_en, 0);
        chk_val("midrst_addr", mem_bus.addr, 0);
        pc = 16'hFFFE;
        mem_wait = 0;
        exp_push(0, 16'hFFFE);
        exp_push(0, 16'h0000);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        fetch_byte(16'hFFFE, 8'h5A, w);
        fetch_byte(16'hFFFF, 8'hA5, w);
        fetch_byte(16'h0000, 8'h11, w);
        fetch_byte(16'h0001, 8'h22, w);
        chk_val("wrap_reqs_left", exp_req.size(), 0);

        chk_val("count_max", (max_cnt <= 4), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
